pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_gen_if.sv | 13 +
 rtl/pwm_gen.sv | 149 ++++++++++++++
 tb/tb_pwm_gen.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_gen_if.sv
// Configuration handshake for pwm_gen: the producer offers a period/duty pair,
// and pwm_gen accepts it when its shadow register is free.
interface pwm_gen_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_duty;

  modport master (output cfg_valid, output cfg_period, output cfg_duty, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_period, input  cfg_duty, output cfg_ready);
endinterface

// File: rtl/pwm_gen.sv
// Tick-driven PWM generator with a shadowed period/duty update applied at the counter wrap.
// Optional complementary output with dead time when PWM_COMPL_EN is defined.
module pwm_gen #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEADTIME    = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      tick_in,
  pwm_gen_if.slave  cfg,
  output logic      pwm_out,
  output logic      period_start
`ifdef PWM_COMPL_EN
  ,
  output logic      pwm_n
`endif
);

  if (SYNC_STAGES < 2 || DEADTIME < 0) begin : g_bad_param
    $error("pwm_gen: SYNC_STAGES must be >= 2 and DEADTIME >= 0");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       p_act_q, p_act_d;
  logic [WIDTH-1:0]       d_act_q, d_act_d;
  logic [WIDTH-1:0]       shadow_period_q, shadow_period_d;
  logic [WIDTH-1:0]       shadow_duty_q, shadow_duty_d;
  logic                   pending_q, pending_d;
  logic                   raw_pwm_q, raw_pwm_d;
  logic                   period_start_q, period_start_d;

  logic                   sync_out;
  logic                   tick;
  logic                   wrap;
  logic                   cfg_fire;
  logic [WIDTH-1:0]       duty_use;

  assign cfg.cfg_ready = ~pending_q;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sync_d          = {sync_q[SYNC_STAGES-2:0], tick_in};
    sync_out        = sync_q[SYNC_STAGES-1];
    sync_prev_d     = sync_out;
    tick            = sync_out & ~sync_prev_q;
    wrap            = tick & (cnt_q == p_act_q);
    cfg_fire        = cfg.cfg_valid & ~pending_q;

    cnt_d           = cnt_q;
    p_act_d         = p_act_q;
    d_act_d         = d_act_q;
    shadow_period_d = shadow_period_q;
    shadow_duty_d   = shadow_duty_q;
    pending_d       = pending_q;
    raw_pwm_d       = raw_pwm_q;
    period_start_d  = wrap;
    duty_use        = d_act_q;

    if (tick) begin
      cnt_d     = wrap ? '0 : WIDTH'(cnt_q + 1'b1);
      // A pending update takes effect on the wrap itself, so the first tick of the
      // new period is already compared against the new duty.
      duty_use  = (wrap && pending_q) ? shadow_duty_q : d_act_q;
      raw_pwm_d = (cnt_d < duty_use);
    end

    if (wrap && pending_q) begin
      p_act_d   = shadow_period_q;
      d_act_d   = shadow_duty_q;
      pending_d = 1'b0;
    end

    if (cfg_fire) begin
      shadow_period_d = cfg.cfg_period;
      shadow_duty_d   = cfg.cfg_duty;
      pending_d       = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q          <= '0;
      sync_prev_q     <= 1'b0;
      cnt_q           <= '0;
      p_act_q         <= '1;
      d_act_q         <= '0;
      shadow_period_q <= '0;
      shadow_duty_q   <= '0;
      pending_q       <= 1'b0;
      raw_pwm_q       <= 1'b0;
      period_start_q  <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      sync_prev_q     <= sync_prev_d;
      cnt_q           <= cnt_d;
      p_act_q         <= p_act_d;
      d_act_q         <= d_act_d;
      shadow_period_q <= shadow_period_d;
      shadow_duty_q   <= shadow_duty_d;
      pending_q       <= pending_d;
      raw_pwm_q       <= raw_pwm_d;
      period_start_q  <= period_start_d;
    end
  end

  assign period_start = period_start_q;

`ifdef PWM_COMPL_EN
  localparam int             DT_W   = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [DT_W-1:0] DT_MAX = DT_W'(DEADTIME);

  logic [DT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [DT_W-1:0] lo_cnt_q, lo_cnt_d;

  // Each counter measures how long its phase of the raw PWM has been active;
  // an output is released only once its phase has lasted DEADTIME cycles.
  always_comb begin
    hi_cnt_d = '0;
    lo_cnt_d = '0;
    if (raw_pwm_q) begin
      hi_cnt_d = (hi_cnt_q == DT_MAX) ? hi_cnt_q : DT_W'(hi_cnt_q + 1'b1);
    end else begin
      lo_cnt_d = (lo_cnt_q == DT_MAX) ? lo_cnt_q : DT_W'(lo_cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  assign pwm_out = raw_pwm_q & (hi_cnt_q == DT_MAX);
  assign pwm_n   = ~raw_pwm_q & (lo_cnt_q == DT_MAX);
`else
  assign pwm_out = raw_pwm_q;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: table of period/duty scenarios plus hand-written
// sequences for handshake, latency, reset and dead-time corner cases.
module tb_pwm_gen;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int DT    = 4;

  logic clk = 1'b0;
  logic rst;
  logic tick_in;
  logic pwm_out;
  logic period_start;
`ifdef PWM_COMPL_EN
  logic pwm_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_gen_if #(.WIDTH(WIDTH)) cfg_if ();

  pwm_gen #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEADTIME(DT)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_in      (tick_in),
    .cfg          (cfg_if),
    .pwm_out      (pwm_out),
    .period_start (period_start)
`ifdef PWM_COMPL_EN
    ,
    .pwm_n        (pwm_n)
`endif
  );

  typedef struct {
    string      name;
    logic [7:0] p;
    logic [7:0] d;
    int         exp_high;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    tick_in             = 1'b0;
    cfg_if.cfg_valid    = 1'b0;
    cfg_if.cfg_period   = '0;
    cfg_if.cfg_duty     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One tick = tick_in high for 4 clk, low for 4 clk; called at a negedge.
  task automatic do_tick(output logic ps, output logic pw);
    ps      = 1'b0;
    tick_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (period_start) ps = 1'b1;
      if (i == 3) tick_in = 1'b0;
    end
    pw = pwm_out;
  endtask

  task automatic offer(input logic [7:0] p, input logic [7:0] d);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = p;
    cfg_if.cfg_duty   = d;
    @(negedge clk);
    cfg_if.cfg_valid  = 1'b0;
  endtask

  // Tick until a wrap is seen; returns the pwm value of the wrap tick.
  task automatic tick_to_wrap(input string name, output logic pw);
    logic ps;
    logic found;
    found = 1'b0;
    pw    = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      do_tick(ps, pw);
      if (ps) found = 1'b1;
    end
    check({name, "_wrap_found"}, int'(found), 1);
  endtask

  // Apply a config from reset, then observe two full periods starting at the wrap.
  task automatic run_vec(input vec_t v);
    logic ps, pw;
    int   len, high, ps_err, pat_err;
    do_reset();
    offer(v.p, v.d);
    tick_to_wrap(v.name, pw);
    len     = int'(v.p) + 1;
    high    = int'(pw);
    ps_err  = 0;
    pat_err = (int'(pw) != int'(0 < v.exp_high)) ? 1 : 0;
    for (int i = 1; i < 2 * len; i++) begin
      do_tick(ps, pw);
      high += int'(pw);
      if (ps != ((i % len) == 0)) ps_err++;
      if (pw != ((i % len) < v.exp_high)) pat_err++;
    end
    check({v.name, "_high"}, high, 2 * v.exp_high);
    check({v.name, "_ps"}, ps_err, 0);
    check({v.name, "_pattern"}, pat_err, 0);
  endtask

`ifdef PWM_COMPL_EN
  logic mon_en    = 1'b0;
  int   overlap   = 0;
  int   low_run   = 0;
  int   runs      = 0;
  int   bad_runs  = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pwm_out && pwm_n) overlap++;
      if (!pwm_out && !pwm_n) begin
        low_run++;
      end else begin
        if (low_run != 0) begin
          runs++;
          if (low_run != DT) bad_runs++;
        end
        low_run = 0;
      end
    end
  end
`endif

  initial begin
    logic ps, pw;
    int   high, ps_cnt, ps_at, rdy_low, n;

    vecs[0] = '{"p9_d3",  8'd9, 8'd3, 3};
    vecs[1] = '{"p4_d5",  8'd4, 8'd5, 5};
    vecs[2] = '{"p4_d0",  8'd4, 8'd0, 0};
    vecs[3] = '{"p0_d0",  8'd0, 8'd0, 0};
    vecs[4] = '{"p0_d1",  8'd0, 8'd1, 1};
    vecs[5] = '{"p7_d7",  8'd7, 8'd7, 7};
    vecs[6] = '{"p7_d8",  8'd7, 8'd8, 8};

    // Reset state and free-running default period of 256 ticks
    do_reset();
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ps", int'(period_start), 0);
    check("rst_ready", int'(cfg_if.cfg_ready), 1);
    high = 0; ps_cnt = 0; ps_at = -1; rdy_low = 0;
    for (int i = 0; i < 300; i++) begin
      do_tick(ps, pw);
      high += int'(pw);
      if (ps) begin ps_cnt++; ps_at = i; end
      if (!cfg_if.cfg_ready) rdy_low++;
    end
    check("idle_high", high, 0);
    check("idle_ps_count", ps_cnt, 1);
    check("idle_ps_index", ps_at, 255);
    check("idle_ready_low", rdy_low, 0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Latency from tick_in rising to period_start, with P=0 active
    do_reset();
    offer(8'd0, 8'd0);
    tick_to_wrap("lat", pw);
    tick_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(negedge clk);
      if (period_start) n = i;
    end
    if (n == 0) n = 99;
    check("latency", n, SYNC + 1);
    tick_in = 1'b0;
    repeat (6) @(negedge clk);

    // Transfer in the same cycle as a wrap with nothing pending: captured only
    tick_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) begin
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = 8'd0;
        cfg_if.cfg_duty   = 8'd1;
      end
      if (i == 3) cfg_if.cfg_valid = 1'b0;
      if (i == 4) tick_in = 1'b0;
    end
    check("same_cycle_old_duty", int'(pwm_out), 0);
    check("same_cycle_pending", int'(cfg_if.cfg_ready), 0);
    do_tick(ps, pw);
    check("same_cycle_new_duty", int'(pw), 1);
    check("same_cycle_ready", int'(cfg_if.cfg_ready), 1);

    // Second offer while pending is ignored; re-offer after the wrap is applied
    do_reset();
    offer(8'd9, 8'd3);
    check("pend_ready_low", int'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 8'd4;
    cfg_if.cfg_duty   = 8'd1;
    repeat (5) do_tick(ps, pw);
    check("pend_ready_held", int'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_valid = 1'b0;
    tick_to_wrap("pend", pw);
    check("pend_ready_free", int'(cfg_if.cfg_ready), 1);
    high = int'(pw);
    offer(8'd4, 8'd1);
    ps_cnt = 0;
    for (int i = 1; i < 10; i++) begin
      do_tick(ps, pw);
      high += int'(pw);
      ps_cnt += int'(ps);
    end
    check("pend_first_high", high, 3);
    check("pend_first_ps", ps_cnt, 0);
    high = 0; ps_cnt = 0; ps_at = -1;
    for (int i = 0; i < 6; i++) begin
      do_tick(ps, pw);
      if (i < 5) high += int'(pw);
      if (ps) begin ps_cnt++; ps_at = i; end
    end
    check("pend_second_high", high, 1);
    check("pend_second_ps_count", ps_cnt, 2);
    check("pend_second_ps_last", ps_at, 5);

    // Reset mid-period with a pending update
    do_reset();
    offer(8'd9, 8'd9);
    tick_to_wrap("rstmid", pw);
    do_tick(ps, pw);
    check("rstmid_pre_pwm", int'(pw), 1);
    offer(8'd0, 8'd1);
    tick_in = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_pwm", int'(pwm_out), 0);
    check("rstmid_ps", int'(period_start), 0);
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", int'(cfg_if.cfg_ready), 1);
    high = 0; ps_cnt = 0; ps_at = -1;
    for (int i = 0; i < 256; i++) begin
      do_tick(ps, pw);
      high += int'(pw);
      if (ps) begin ps_cnt++; ps_at = i; end
    end
    check("rstmid_high", high, 0);
    check("rstmid_ps_count", ps_cnt, 1);
    check("rstmid_ps_index", ps_at, 255);

`ifdef PWM_COMPL_EN
    // Dead time between complementary outputs
    do_reset();
    offer(8'd9, 8'd5);
    tick_to_wrap("dt", pw);
    low_run = 0;
    mon_en  = 1'b1;
    repeat (10) do_tick(ps, pw);
    mon_en  = 1'b0;
    check("dt_overlap", overlap, 0);
    check("dt_runs", runs, 2);
    check("dt_bad_runs", bad_runs, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
